// File: rtl/spi_frame_master_pkg.sv
// Shared SPI link definitions: FSM state encoding, frame geometry and the command read flag.
// Imported by the frame master and by the SPI-to-Wishbone slave controller.
package spi_defs;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } spi_state_e;

    localparam int unsigned SPI_CTL_SIZE_DEF = 8;
    localparam int unsigned WB_ADR_SIZE_DEF  = 8;
    localparam int unsigned WB_DAT_SIZE_DEF  = 8;
    localparam int unsigned SPI_FRAME_W      = SPI_CTL_SIZE_DEF + WB_ADR_SIZE_DEF
                                               + WB_DAT_SIZE_DEF;

    // MSB of the command byte selects a read.
    localparam int unsigned SPI_RD_FLAG_BIT = SPI_CTL_SIZE_DEF - 1;

    function automatic logic spi_cmd_is_read(input logic [SPI_CTL_SIZE_DEF-1:0] cmd);
        return cmd[SPI_RD_FLAG_BIT];
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider: o_tick is high for one cycle every CLK_DIV cycles, o_pre_tick the
// cycle before it. i_clear restarts the period so the first tick lands CLK_DIV cycles later.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

    if (CLK_DIV > 1) begin : g_pre
        assign o_pre_tick = (r_cnt == CW'(CLK_DIV - 2));
    end else begin : g_no_pre
        assign o_pre_tick = 1'b0;
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master emitting one {cmd, adr, dat} frame per accepted request and returning
// the byte sampled on MISO during the data field.
module spi_frame_master
    import spi_defs::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned SPI_CTL_SIZE = SPI_CTL_SIZE_DEF,
    parameter int unsigned WB_ADR_SIZE  = WB_ADR_SIZE_DEF,
    parameter int unsigned WB_DAT_SIZE  = WB_DAT_SIZE_DEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [SPI_CTL_SIZE-1:0] req_cmd_i,
    input  logic [WB_ADR_SIZE-1:0]  req_adr_i,
    input  logic [WB_DAT_SIZE-1:0]  req_dat_i,
    output logic                    rsp_valid_o,
    output logic [WB_DAT_SIZE-1:0]  rsp_dat_o,
    output logic                    busy_o,
    output logic                    spi_sck_o,
    output logic                    spi_mosi_o,
    input  logic                    spi_miso_i,
    output logic                    spi_ss_o
);

    localparam int unsigned N  = SPI_CTL_SIZE + WB_ADR_SIZE + WB_DAT_SIZE;
    localparam int unsigned BW = $clog2(2 * N + 1);
    localparam logic [BW-1:0] LAST_EDGE = BW'(2 * N);

    spi_state_e             r_state;
    logic [N-1:0]           r_tx;
    logic [WB_DAT_SIZE-1:0] r_rx;
    logic [BW-1:0]          r_edge;
    logic                   r_sck;
    logic                   r_mosi;
    logic                   r_ss;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_rsp_valid;
    logic [WB_DAT_SIZE-1:0] r_rsp_dat;

    logic         w_accept;
    logic         w_tick;
    logic         w_pre_tick;
    logic [N-1:0] w_frame;

    assign w_frame  = {req_cmd_i, req_adr_i, req_dat_i};
    assign w_accept = req_valid_i && r_ready;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk      (wb_clk_i),
        .i_rst_n    (wb_rst_ni),
        .i_clear    (w_accept),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // r_edge counts SCK transitions; 2N means the last low phase has started.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= StIdle;
            r_tx        <= '0;
            r_rx        <= '0;
            r_edge      <= '0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_ss        <= 1'b1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_state <= StSetup;
                r_tx    <= w_frame;
                r_mosi  <= w_frame[N-1];
                r_ss    <= 1'b0;
                r_sck   <= 1'b0;
                r_edge  <= '0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_sck <= 1'b0;
                        r_ss  <= 1'b1;
                    end
                    StSetup: begin
                        if (w_tick) begin
                            r_state <= StShift;
                            r_sck   <= 1'b1;
                            r_rx    <= {r_rx[WB_DAT_SIZE-2:0], spi_miso_i};
                            r_edge  <= r_edge + 1'b1;
                        end
                    end
                    StShift: begin
                        if (w_tick) begin
                            if (r_sck) begin
                                r_sck  <= 1'b0;
                                r_tx   <= {r_tx[N-2:0], 1'b0};
                                r_mosi <= r_tx[N-2];
                                r_edge <= r_edge + 1'b1;
                            end else if (r_edge == LAST_EDGE) begin
                                r_state     <= StGap;
                                r_ss        <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_rsp_dat   <= r_rx;
                                // No pre-tick exists at CLK_DIV=1, so ready opens on entry.
                                if (CLK_DIV == 1) begin
                                    r_ready <= 1'b1;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_sck  <= 1'b1;
                                r_rx   <= {r_rx[WB_DAT_SIZE-2:0], spi_miso_i};
                                r_edge <= r_edge + 1'b1;
                            end
                        end
                    end
                    StGap: begin
                        // Open ready one cycle early so the next accept lands on the GAP exit edge.
                        if (w_pre_tick) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                        if (w_tick) begin
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign spi_sck_o   = r_sck;
    assign spi_mosi_o  = r_mosi;
    assign spi_ss_o    = r_ss;

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: instance 0 runs CLK_DIV=4, instance 1 CLK_DIV=1.
module tb_spi_frame_master;

    localparam int N = 24;

    typedef struct {
        int          inst;
        logic [23:0] frame;
        logic [7:0]  rd;
        longint      e0;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] busy;
    logic [1:0] sck;
    logic [1:0] mosi;
    logic [1:0] ss;
    logic [7:0] req_cmd [2];
    logic [7:0] req_adr [2];
    logic [7:0] req_dat [2];
    logic [7:0] rsp_dat [2];

    exp_t       sb[$];
    logic [7:0] mq[$];
    longint     cyc = 0;
    int         total = 0;
    int         bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 1;

        logic        miso_b = 1'b0;
        logic [23:0] cap = '0;
        int          npulse = 0;
        logic [7:0]  cur = '0;
        int          idx = 0;
        bit          in_frame = 1'b0;
        bit          prev_rv = 1'b0;
        bit          prev_ready = 1'b0;
        longint      ready_due = 0;
        exp_t        e;

        spi_frame_master #(
            .CLK_DIV (D)
        ) u_dut (
            .wb_clk_i    (clk),
            .wb_rst_ni   (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_cmd_i   (req_cmd[g]),
            .req_adr_i   (req_adr[g]),
            .req_dat_i   (req_dat[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_dat_o   (rsp_dat[g]),
            .busy_o      (busy[g]),
            .spi_sck_o   (sck[g]),
            .spi_mosi_o  (mosi[g]),
            .spi_miso_i  (miso_b),
            .spi_ss_o    (ss[g])
        );

        // Slave-side view of MOSI: one bit per SCK rise while selected.
        always @(posedge sck[g] or negedge ss[g]) begin
            if (sck[g]) begin
                cap = {cap[22:0], mosi[g]};
                npulse++;
            end else begin
                cap    = '0;
                npulse = 0;
            end
        end

        // Mode-0 slave: junk during cmd/adr, queued read byte during the data field.
        always @(ss[g] or negedge sck[g]) begin
            if (ss[g]) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    idx      = 0;
                    cur      = (mq.size() > 0) ? mq.pop_front() : 8'h00;
                end else begin
                    idx++;
                end
                miso_b = (idx >= 16 && idx < 24) ? cur[23-idx] : 1'($urandom_range(0, 1));
            end
        end

        always @(negedge clk) begin
            if (rsp_valid[g]) begin
                chk("rsp_pulse_width", prev_rv, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: inst %0d pulsed rsp_valid, none pending", g);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_inst", g, e.inst);
                    chk("mosi_frame", cap, e.frame);
                    chk("sck_pulses", npulse, N);
                    chk("rsp_dat", rsp_dat[g], e.rd);
                    chk("rsp_cycle", cyc, e.e0 + (2 * N + 1) * D);
                    chk("ss_high_at_rsp", ss[g], 1);
                    ready_due = e.e0 + (2 * N + 2) * D;
                end
            end
            if (req_ready[g] && !prev_ready && ready_due != 0) begin
                chk("ready_cycle", cyc + 1, ready_due);
                ready_due = 0;
            end
            prev_rv    = rsp_valid[g];
            prev_ready = req_ready[g];
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int i, input logic [7:0] c, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] rd, input bit push,
                        input bit hold, output longint e0);
        bit r;
        bit ok;
        ok = 1'b0;
        mq.push_back(rd);
        req_cmd[i]   = c;
        req_adr[i]   = a;
        req_dat[i]   = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            r = req_ready[i];
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        e0 = cyc;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: inst %0d request never accepted", i);
        end else if (push) begin
            sb.push_back('{inst: i, frame: {c, a, d}, rd: rd, e0: cyc});
        end
        if (!hold) req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            if (sb.size() == 0 && req_ready == 2'b11) break;
            @(negedge clk);
        end
        chk("queue_drained", sb.size(), 0);
        chk("ready_after_drain", req_ready, 2'b11);
    endtask

    initial begin
        longint     e0a;
        longint     e0b;
        longint     rel;
        logic [7:0] c, a, d, rd;

        rst_n     = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_cmd[i] = '0;
            req_adr[i] = '0;
            req_dat[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ss", ss[i], 1);
            chk("rst_sck", sck[i], 0);
            chk("rst_mosi", mosi[i], 0);
            chk("rst_ready", req_ready[i], 1);
            chk("rst_busy", busy[i], 0);
            chk("rst_rsp_valid", rsp_valid[i], 0);
            chk("rst_rsp_dat", rsp_dat[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Plain write and read at CLK_DIV=4.
        send(0, 8'h00, 8'h34, 8'h5A, 8'($urandom), 1, 0, e0a);
        drain();
        send(0, 8'h80, 8'h12, 8'($urandom), 8'hA5, 1, 0, e0a);
        drain();

        // Inputs scrambled right after accept; the new request waits for ready.
        send(0, 8'h3C, 8'h55, 8'h0F, 8'h96, 1, 1, e0a);
        rd = 8'($urandom);
        send(0, 8'hFF, 8'hFF, 8'hFF, rd, 1, 0, e0b);
        chk("held_req_accept_gap", e0b - e0a, (2 * N + 2) * 4);
        drain();

        for (int k = 0; k < 4; k++) begin
            c  = 8'($urandom);
            a  = 8'($urandom);
            d  = 8'($urandom);
            rd = 8'($urandom);
            send(0, c, a, d, rd, 1, 0, e0a);
            drain();
        end

        // Reset during bit 10's high phase, then release with a request already waiting.
        send(0, 8'h80, 8'h77, 8'h00, 8'h3C, 0, 0, e0a);
        for (int n = 0; n < 1000; n++) begin
            if (cyc >= e0a + (2 * 10 + 1) * 4 + 2) break;
            @(negedge clk);
        end
        chk("busy_mid_frame", busy[0], 1);
        chk("sck_high_bit10", sck[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ss", ss[0], 1);
        chk("abort_sck", sck[0], 0);
        chk("abort_ready", req_ready[0], 1);
        chk("abort_busy", busy[0], 0);
        chk("abort_rsp_valid", rsp_valid[0], 0);
        c  = 8'h00;
        a  = 8'hC3;
        d  = 8'h81;
        rd = 8'($urandom);
        req_cmd[0]   = c;
        req_adr[0]   = a;
        req_dat[0]   = d;
        req_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        send(0, c, a, d, rd, 1, 0, e0a);
        chk("accept_first_edge_after_release", e0a, rel + 1);
        drain();

        // Back-to-back at CLK_DIV=1 with valid held high.
        send(1, 8'h00, 8'h01, 8'h11, 8'($urandom), 1, 1, e0a);
        send(1, 8'h80, 8'h01, 8'h00, 8'h5C, 1, 1, e0b);
        chk("b2b_accept_gap", e0b - e0a, 2 * N + 2);
        for (int k = 0; k < 4; k++) begin
            e0a = e0b;
            c   = 8'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            rd  = 8'($urandom);
            send(1, c, a, d, rd, 1, (k < 3), e0b);
            chk("b2b_rand_gap", e0b - e0a, 2 * N + 2);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

SPI master that emits the three-field command/address/data frame consumed by our SPI-to-Wishbone slave controller, and returns the byte shifted back on MISO during the data field. It sits on the host/test side of the link (bring-up fixture, loopback self-test, or a second FPGA driving the MIDI router's register space). A valid/ready request port feeds it, and a one-cycle response strobe reports completion. SCK is derived from the system clock by an integer divider.

## Interface

- `CLK_DIV`, 4, SCK half-period in `wb_clk_i` cycles; legal range ≥1.
- `SPI_CTL_SIZE`, 8, command field width.
- `WB_ADR_SIZE`, 8, address field width.
- `WB_DAT_SIZE`, 8, data field width.

Ports:

- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block idle, can accept.
- `req_cmd_i`  in  SPI_CTL_SIZE  command byte; bit MSB=1 denotes read.
- `req_adr_i`  in  WB_ADR_SIZE  register address.
- `req_dat_i`  in  WB_DAT_SIZE  write data (don't-care value still shifted on reads).
- `rsp_valid_o`  out  1  one-cycle pulse, frame complete.
- `rsp_dat_o`  out  WB_DAT_SIZE  bits sampled from MISO during the data field.
- `busy_o`  out  1  frame in progress (= !req_ready_o).
- `spi_sck_o`  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi_o`  out  1  master out.
- `spi_miso_i`  in  1  master in.
- `spi_ss_o`  out  1  slave select, active-low.

## Operation

- Frame = {cmd, adr, dat}, N = SPI_CTL_SIZE+WB_ADR_SIZE+WB_DAT_SIZE bits (24 default), MSB first.
- Accept when `req_valid_i && req_ready_o` at a rising edge. All request fields are latched into a shift register. Later input changes have no effect.
- States:
  - IDLE: SS high, SCK low, ready high. Leaves on accept → SETUP.
  - SETUP: SS low, MOSI = frame MSB. Lasts CLK_DIV cycles → SHIFT.
  - SHIFT: N bits. Each bit is SCK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - MISO is sampled on the edge that drives SCK high.
    - MOSI advances on the edge that drives SCK low.
    - After the low phase of bit N-1 → GAP.
  - GAP: SS high, `rsp_valid_o` pulses on the entry edge. Lasts CLK_DIV cycles → IDLE.
- `rsp_dat_o` holds the last WB_DAT_SIZE sampled bits (MSB first) and is stable until the next `rsp_valid_o`.
- Requests presented while busy are not accepted; the requester holds them.
- The block never aborts a frame once started, except on reset.
- Reset values:
  - `spi_ss_o`=1, `spi_sck_o`=0, `spi_mosi_o`=0
  - `req_ready_o`=1, `busy_o`=0
  - `rsp_valid_o`=0, `rsp_dat_o`=0
  - state IDLE, counters 0
- Reset asserted mid-frame forces these values immediately, without waiting for a clock edge. The slave then sees SS rise and discards the partial frame.

## Timing

- Accept at edge E0. SS falls and MOSI = bit N-1 are registered at E0.
- Bit k (0 = MSB): SCK rises at E0+(2k+1)·CLK_DIV and falls at E0+(2k+2)·CLK_DIV.
- Last SCK fall is at E0+2N·CLK_DIV. SS rises and `rsp_valid_o`=1 at E0+(2N+1)·CLK_DIV.
- `req_ready_o` returns high at E0+(2N+2)·CLK_DIV. Default: 196 cycles to response, 200 cycles to ready.
- Back-to-back: the next accept is possible on the first ready cycle. SS high time between frames is ≥CLK_DIV cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- CLK_DIV=1: SCK = wb_clk_i/2; all relations above still hold.

## Structure

- Shared package `spi_defs`:
  - state encodings (IDLE/SETUP/SHIFT/GAP)
  - read-flag bit position of the command byte
  - frame-width constant
  
  The existing slave controller imports the same definitions.
- Sub-module `spi_clk_div`: counter producing a one-cycle `tick` every CLK_DIV cycles, cleared on accept. The FSM toggles SCK and advances state only on `tick`.
- Datapath: one N-bit output shift register and one WB_DAT_SIZE-bit input shift register; bit counter of width clog2(2N+1).

## Test plan

- Write, CLK_DIV=4, cmd=0x00, adr=0x34, dat=0x5A. MOSI captured on SCK rises = 0x00345A, exactly 24 SCK pulses, SS low throughout, `rsp_valid_o` at E0+196, ready at E0+200.
- Read, cmd=0x80, adr=0x12, MISO model drives 0xA5 during the data field. MOSI = 0x8012xx, `rsp_dat_o`=0xA5, single-cycle `rsp_valid_o`.
- CLK_DIV=1, back-to-back requests with `req_valid_i` held high (0x00/0x01/0x11 then 0x80/0x01/0x00). Second accept at E0+50, SS high ≥1 cycle between frames, both frames bit-exact.
- Inputs changed to 0xFF/0xFF/0xFF one cycle after accept. MOSI still carries the latched values; the new request is not accepted until ready.
- `wb_rst_ni` pulsed low at bit 10 of a frame. SS=1, SCK=0, ready=1, rsp_valid=0 before the next clock edge; no response pulse for the aborted frame. A following write completes correctly.
- Reset release with `req_valid_i` already high. Accept on the first edge after release; verify frame timing from that edge.
